// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory port between an instruction-fetch
// side and a data side, with a per-access wait timeout and per-side grant counters.
module mem_arbiter #(
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 err,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic [WORD_SIZE-1:0] num_i_grant,
    output logic [WORD_SIZE-1:0] num_d_grant
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]        WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]        WAIT_ONE  = CW'(1);
    localparam logic [WORD_SIZE-1:0] CNT_ONE   = WORD_SIZE'(1);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, DONE} state_t;

    state_t        state;
    logic          last_i;
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_i      <= 1'b1;
            wait_cnt    <= '0;
            i_ack       <= 1'b0;
            d_ack       <= 1'b0;
            err         <= 1'b0;
            i_rdata     <= '0;
            d_rdata     <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            num_i_grant <= '0;
            num_d_grant <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // d wins when alone or when i was granted last
                    if (d_req && (!i_req || last_i)) begin
                        state       <= GNT_D;
                        last_i      <= 1'b0;
                        wait_cnt    <= '0;
                        mem_req     <= 1'b1;
                        mem_we      <= d_we;
                        mem_addr    <= d_addr;
                        mem_wdata   <= d_wdata;
                        num_d_grant <= num_d_grant + CNT_ONE;
                    end else if (i_req) begin
                        state       <= GNT_I;
                        last_i      <= 1'b1;
                        wait_cnt    <= '0;
                        mem_req     <= 1'b1;
                        mem_we      <= 1'b0;
                        mem_addr    <= i_addr;
                        mem_wdata   <= '0;
                        num_i_grant <= num_i_grant + CNT_ONE;
                    end
                end
                GNT_I, GNT_D: begin
                    if (mem_ready || wait_cnt == WAIT_LAST) begin
                        // mem_ready takes precedence over an expiring timeout
                        state   <= DONE;
                        mem_req <= 1'b0;
                        err     <= !mem_ready;
                        if (state == GNT_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            d_ack   <= 1'b1;
                            d_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    i_ack <= 1'b0;
                    d_ack <= 1'b0;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single fetch, tie-break, alternation,
// timeout boundary, reset mid-grant, and grant-counter wrap on an 8-bit instance.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_ready;
    logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_ack, d_ack, err, mem_req, mem_we;
    logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, num_i_grant, num_d_grant;

    // second, narrow instance used only for the grant-counter wrap
    logic       d2_req;
    logic       i2_ack, d2_ack, err2, mem2_req, mem2_we;
    logic [7:0] i2_rdata, d2_rdata, mem2_addr, mem2_wdata, num2_i, num2_d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WORD_SIZE(16), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .num_i_grant(num_i_grant), .num_d_grant(num_d_grant)
    );

    mem_arbiter #(.WORD_SIZE(8), .TIMEOUT(16)) dut8 (
        .clk(clk), .reset(reset),
        .i_req(1'b0), .i_addr(8'h00), .i_ack(i2_ack), .i_rdata(i2_rdata),
        .d_req(d2_req), .d_we(1'b0), .d_addr(8'h11), .d_wdata(8'h00),
        .d_ack(d2_ack), .d_rdata(d2_rdata), .err(err2),
        .mem_req(mem2_req), .mem_we(mem2_we), .mem_addr(mem2_addr), .mem_wdata(mem2_wdata),
        .mem_rdata(8'h5A), .mem_ready(1'b1),
        .num_i_grant(num2_i), .num_d_grant(num2_d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; d2_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = 16'hFFFF; d2_req = 1'b0;
        tick(); tick();
        checks++; if ({i_ack, d_ack, err, mem_req, mem_we} !== 5'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=00000", {i_ack, d_ack, err, mem_req, mem_we}); end
        checks++; if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 64'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, i_rdata, d_rdata}); end
        checks++; if ({num_i_grant, num_d_grant} !== 32'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0", {num_i_grant, num_d_grant}); end
        reset = 1'b0;
        mem_ready = 1'b1;
        tick(); tick();
        checks++; if ({i_ack, d_ack, mem_req, err} !== 4'b0) begin errors++; $display("FAIL ready_in_idle got=%b exp=0000", {i_ack, d_ack, mem_req, err}); end
        mem_ready = 1'b0;
    endtask

    task automatic test_single_fetch();
        do_reset();
        i_req = 1'b1; i_addr = 16'h0010;
        tick();
        checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0010}) begin errors++; $display("FAIL fetch_grant got=%b/%b/%h exp=1/0/0010", mem_req, mem_we, mem_addr); end
        checks++; if (num_i_grant !== 16'd1) begin errors++; $display("FAIL fetch_cnt got=%0d exp=1", num_i_grant); end
        tick(); tick();
        checks++; if ({mem_req, i_ack} !== 2'b10) begin errors++; $display("FAIL fetch_wait got=%b exp=10", {mem_req, i_ack}); end
        mem_ready = 1'b1; mem_rdata = 16'h6000;
        tick();
        mem_ready = 1'b0; i_req = 1'b0;
        checks++; if ({i_ack, d_ack, err, mem_req} !== 4'b1000 || i_rdata !== 16'h6000) begin errors++; $display("FAIL fetch_ack got=%b rdata=%h exp=1000 rdata=6000", {i_ack, d_ack, err, mem_req}, i_rdata); end
        tick();
        checks++; if (i_ack !== 1'b0) begin errors++; $display("FAIL fetch_ack_pulse got=%b exp=0", i_ack); end
    endtask

    task automatic test_tie_break();
        do_reset();
        i_req = 1'b1; i_addr = 16'h0044;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0080; d_wdata = 16'h1234;
        tick();
        checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 16'h0080, 16'h1234}) begin errors++; $display("FAIL tie_d_first got=%b/%h/%h exp=1/0080/1234", mem_we, mem_addr, mem_wdata); end
        mem_ready = 1'b1; mem_rdata = 16'h0BAD;
        tick();
        checks++; if ({d_ack, i_ack, err} !== 3'b100 || d_rdata !== 16'h0BAD) begin errors++; $display("FAIL tie_d_ack got=%b rdata=%h exp=100 rdata=0bad", {d_ack, i_ack, err}, d_rdata); end
        d_req = 1'b0; mem_ready = 1'b0;
        tick(); tick();
        checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0044}) begin errors++; $display("FAIL tie_i_second got=%b/%b/%h exp=1/0/0044", mem_req, mem_we, mem_addr); end
        checks++; if ({num_d_grant, num_i_grant} !== {16'd1, 16'd1}) begin errors++; $display("FAIL tie_cnt got=%0d/%0d exp=1/1", num_d_grant, num_i_grant); end
        mem_ready = 1'b1;
        tick();
        i_req = 1'b0; mem_ready = 1'b0;
        checks++; if ({i_ack, d_ack} !== 2'b10) begin errors++; $display("FAIL tie_i_ack got=%b exp=10", {i_ack, d_ack}); end
        tick();
    endtask

    task automatic test_alternate();
        do_reset();
        i_req = 1'b1; i_addr = 16'h0100;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'hAAAA;
        mem_ready = 1'b1;
        for (int g = 0; g < 6; g++) begin
            logic exp_d;
            exp_d = (g % 2 == 0);
            tick();
            checks++; if (mem_addr !== (exp_d ? 16'h0200 : 16'h0100)) begin errors++; $display("FAIL alt_grant%0d got=%h exp=%h", g, mem_addr, exp_d ? 16'h0200 : 16'h0100); end
            tick();
            checks++; if ({d_ack, i_ack} !== {exp_d, !exp_d}) begin errors++; $display("FAIL alt_ack%0d got=%b exp=%b", g, {d_ack, i_ack}, {exp_d, !exp_d}); end
            tick();
        end
        checks++; if ({num_d_grant, num_i_grant} !== {16'd3, 16'd3}) begin errors++; $display("FAIL alt_cnt got=%0d/%0d exp=3/3", num_d_grant, num_i_grant); end
        i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200; mem_rdata = 16'hBEEF;
        tick();
        for (int c = 1; c < 16; c++) begin
            tick();
            checks++; if ({d_ack, err, mem_req} !== 3'b001) begin errors++; $display("FAIL to_wait%0d got=%b exp=001", c, {d_ack, err, mem_req}); end
        end
        tick();
        d_req = 1'b0;
        checks++; if ({d_ack, err, mem_req} !== 3'b110 || d_rdata !== 16'h0000) begin errors++; $display("FAIL to_expire got=%b rdata=%h exp=110 rdata=0000", {d_ack, err, mem_req}, d_rdata); end
        tick();
        checks++; if ({d_ack, err} !== 2'b00) begin errors++; $display("FAIL to_err_pulse got=%b exp=00", {d_ack, err}); end
        d_req = 1'b1; d_addr = 16'h0300;
        tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; d_req = 1'b0;
        checks++; if ({d_ack, err} !== 2'b10 || d_rdata !== 16'hBEEF) begin errors++; $display("FAIL to_recover got=%b rdata=%h exp=10 rdata=beef", {d_ack, err}, d_rdata); end
        tick();
        // mem_ready landing on the final wait cycle counts as success
        d_req = 1'b1; mem_rdata = 16'h1357;
        tick();
        for (int c = 1; c < 16; c++) tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0; d_req = 1'b0;
        checks++; if ({d_ack, err} !== 2'b10 || d_rdata !== 16'h1357) begin errors++; $display("FAIL to_same_edge got=%b rdata=%h exp=10 rdata=1357", {d_ack, err}, d_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0055; d_wdata = 16'h0077;
        tick(); tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmg_granted got=%b exp=1", mem_req); end
        reset = 1'b1;
        tick();
        checks++; if ({i_ack, d_ack, err, mem_req, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata, num_i_grant, num_d_grant} !== '0) begin errors++; $display("FAIL rmg_clear got=%b%b%b%b%b %h %h cnt=%0d/%0d exp=all 0", i_ack, d_ack, err, mem_req, mem_we, mem_addr, mem_wdata, num_i_grant, num_d_grant); end
        reset = 1'b0; d_req = 1'b0;
        tick();
        checks++; if ({d_ack, mem_req} !== 2'b00) begin errors++; $display("FAIL rmg_no_ack got=%b exp=00", {d_ack, mem_req}); end
    endtask

    task automatic test_counter_wrap();
        int acks;
        int cyc;
        do_reset();
        acks = 0;
        cyc  = 0;
        d2_req = 1'b1;
        while (acks < 256 && cyc < 2000) begin
            tick();
            cyc++;
            if (d2_ack) begin
                acks++;
                if (acks == 255) begin
                    checks++; if (num2_d !== 8'hFF) begin errors++; $display("FAIL wrap_max got=%h exp=ff", num2_d); end
                end
                if (acks == 256) begin
                    checks++; if (num2_d !== 8'h00) begin errors++; $display("FAIL wrap_zero got=%h exp=00", num2_d); end
                end
            end
        end
        checks++; if (acks !== 256) begin errors++; $display("FAIL wrap_timeout got=%0d exp=256", acks); end
        d2_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_tie_break();
        test_alternate();
        test_timeout();
        test_reset_mid_grant();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    always @(negedge clk) begin
        if (i_ack && d_ack) begin
            checks++;
            errors++;
            $display("FAIL ack_overlap got=11 exp=not both");
        end
    end

endmodule
